sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
- Shares the single SRAM_Controller port between two requesters, M0 and M1, for example the BIST engine and a host/loader unit.
- Issues at most one single-beat transfer (read or write) per cycle.
- Arbitration is round-robin with a bounded burst hold.
- Tracks in-flight reads so that returning read data is flagged valid only to the requester that issued the read.

Parameters:
- READ_LATENCY, 3: cycles from SRAM_address/SRAM_we_n presented to SRAM_Controller until SRAM_read_data holds the word. Legal range 1..8.
- MAX_BURST, 4: maximum number of consecutive grants to one master while the other master is requesting. Legal range 1..15.

Ports:
- Clock  in  1  50 MHz system clock.
- Resetn  in  1  asynchronous reset, active low.
- SRAM_ready  in  1  SRAM_Controller ready; no grants are issued while low.
- M0_req  in  1  M0 requests a transfer this cycle.
- M0_address  in  18  M0 word address.
- M0_we_n  in  1  0 = write, 1 = read.
- M0_write_data  in  16  M0 write data.
- M0_grant  out  1  M0 request accepted this cycle (combinational).
- M0_read_data  out  16  SRAM_read_data passed through unregistered.
- M0_read_valid  out  1  M0_read_data holds M0's read this cycle.
- M1_req, M1_address, M1_we_n, M1_write_data, M1_grant, M1_read_data, M1_read_valid: same widths and meanings as the M0 ports, for M1.
- SRAM_address  out  18  registered address to SRAM_Controller.
- SRAM_write_data  out  16  registered write data.
- SRAM_we_n  out  1  registered write enable, active low.
- SRAM_read_data  in  16  read data from SRAM_Controller.

Behaviour:
- Reset (async, Resetn=0):
  - SRAM_address=0, SRAM_write_data=0, SRAM_we_n=1.
  - Both grants=0, both read_valid=0.
  - Read-tag pipeline cleared.
  - last_owner=M0, burst_cnt=0.
- Acceptance and issue:
  - Mx_grant is high in cycle t only if Mx_req=1 and SRAM_ready=1.
  - At the end of cycle t, Mx_address, Mx_we_n and Mx_write_data are registered onto the SRAM_* outputs, which are valid in cycle t+1.
  - The requester may change its inputs in cycle t+1.
- Idle cycles: with no grant, SRAM_we_n=1 next cycle; SRAM_address and SRAM_write_data hold their previous values.
- Arbitration, evaluated each cycle with SRAM_ready=1:
  - Only one master requesting: grant it.
  - Both requesting: grant last_owner if burst_cnt < MAX_BURST; otherwise grant the other master.
  - Neither requesting: no grant, burst_cnt <= 0, last_owner unchanged.
- Burst counter update:
  - Grant to last_owner: burst_cnt <= burst_cnt+1, saturating at MAX_BURST.
  - Grant to the other master: last_owner <= that master, burst_cnt <= 1.
  - MAX_BURST=1 gives strict alternation under contention.
  - First contended grant after reset goes to M0.
- Read return:
  - A granted read (we_n=1) pushes tag {valid=1, owner} into a READ_LATENCY-deep shift pipeline at the end of the grant cycle.
  - Writes and idle cycles push valid=0.
  - Mx_read_valid=1 in cycle t+1+READ_LATENCY, when the pipeline head is valid and owner=x; it is registered from the pipeline.
  - Exactly one of M0_read_valid/M1_read_valid can be high per cycle.
- SRAM_ready=0:
  - No grants; SRAM_we_n=1 next cycle.
  - Pipeline keeps shifting, so in-flight reads still return.
  - burst_cnt and last_owner are held.
- Reset mid-operation: all in-flight reads are dropped; no read_valid is asserted after Resetn rises for reads issued before reset.
- Write-after-read ordering is in grant order; no reordering. A read issued after a write to the same address returns the new data.

Test Plan:
- Reset check: Resetn pulse low mid-cycle -> immediately SRAM_we_n=1, SRAM_address=0, grants=0, read_valid=0.
- M0 alone writes data 16'hA000+i to addresses 0..3 in consecutive cycles t..t+3 -> M0_grant high t..t+3; SRAM_we_n=0 in t+1..t+4 with matching address/data; SRAM_we_n=1 at t+5.
- Contention: M0_req=M1_req=1 continuously after reset, MAX_BURST=4 -> grant sequence M0×4, M1×4, M0×4. With MAX_BURST=1 -> M0,M1,M0,M1.
- Reads: M0 reads address 10 (holding 16'h1234) at cycle t and M1 reads address 11 (holding 16'h5678) at t+1, READ_LATENCY=3:
  - M0_read_valid only at t+4 with data 16'h1234.
  - M1_read_valid only at t+5 with data 16'h5678.
  - Never both high in the same cycle.
- SRAM_ready dropped for 3 cycles during a two-master read stream -> no grants, SRAM_we_n=1 during the gap; the read granted just before the drop still returns valid at grant+4; resumption honours the held burst_cnt.
- Resetn asserted for 1 cycle one cycle after an M1 read grant -> no M1_read_valid ever appears for that read; arbitration restarts with M0 priority.

Source files
------------

// File: rtl/sram_arbiter_if.sv
// Signal bundle between two requesters, the SRAM arbiter and SRAM_Controller.
// The arbiter uses the slave view; the requesters and the controller use the master view.
interface sram_arbiter_if;
  logic        M0_req;
  logic [17:0] M0_address;
  logic        M0_we_n;
  logic [15:0] M0_write_data;
  logic        M0_grant;
  logic [15:0] M0_read_data;
  logic        M0_read_valid;

  logic        M1_req;
  logic [17:0] M1_address;
  logic        M1_we_n;
  logic [15:0] M1_write_data;
  logic        M1_grant;
  logic [15:0] M1_read_data;
  logic        M1_read_valid;

  logic        SRAM_ready;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_write_data;
  logic        SRAM_we_n;
  logic [15:0] SRAM_read_data;

  modport slave (
    input  M0_req, M0_address, M0_we_n, M0_write_data,
    output M0_grant, M0_read_data, M0_read_valid,
    input  M1_req, M1_address, M1_we_n, M1_write_data,
    output M1_grant, M1_read_data, M1_read_valid,
    input  SRAM_ready, SRAM_read_data,
    output SRAM_address, SRAM_write_data, SRAM_we_n
  );

  modport master (
    output M0_req, M0_address, M0_we_n, M0_write_data,
    input  M0_grant, M0_read_data, M0_read_valid,
    output M1_req, M1_address, M1_we_n, M1_write_data,
    input  M1_grant, M1_read_data, M1_read_valid,
    output SRAM_ready, SRAM_read_data,
    input  SRAM_address, SRAM_write_data, SRAM_we_n
  );
endinterface

// File: rtl/sram_arbiter.sv
// Two-master round-robin arbiter for the single SRAM_Controller port, with bounded burst hold
// and a read-tag pipeline that routes returning read data to the requester that issued it.
module sram_arbiter #(
  parameter int READ_LATENCY = 3,
  parameter int MAX_BURST    = 4
) (
  input  logic          Clock,
  input  logic          Resetn,
  sram_arbiter_if.slave bus
);
  localparam int NUM_M = 2;
  localparam int AW    = 18;
  localparam int DW    = 16;
  localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

  typedef enum logic { OWN_M0 = 1'b0, OWN_M1 = 1'b1 } owner_e;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          we_n;
    logic [DW-1:0] wdata;
  } req_t;

  typedef struct packed {
    logic   vld;
    owner_e owner;
  } tag_t;

  logic   [NUM_M-1:0] req;
  req_t   [NUM_M-1:0] m_req;
  logic   [NUM_M-1:0] gnt;
  logic               any_gnt;
  owner_e             gnt_owner;
  owner_e             contend_pick;
  req_t               sel;

  owner_e             last_owner_d, last_owner_q;
  logic   [3:0]       burst_cnt_d, burst_cnt_q;
  logic   [AW-1:0]    sram_addr_d, sram_addr_q;
  logic   [DW-1:0]    sram_wdata_d, sram_wdata_q;
  logic               sram_we_n_d, sram_we_n_q;
  tag_t   [READ_LATENCY-1:0] tag_d, tag_q;
  logic   [NUM_M-1:0] rv_d, rv_q;

  assign req[0]   = bus.M0_req;
  assign req[1]   = bus.M1_req;
  assign m_req[0] = {bus.M0_address, bus.M0_we_n, bus.M0_write_data};
  assign m_req[1] = {bus.M1_address, bus.M1_we_n, bus.M1_write_data};

  // Under contention the current owner keeps the port until its burst budget is spent.
  assign contend_pick = (burst_cnt_q < BURST_MAX) ? last_owner_q : owner_e'(~last_owner_q);

  always_comb begin
    gnt = '0;
    if (Resetn && bus.SRAM_ready) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (contend_pick == OWN_M1) ? 2'b10 : 2'b01;
        default: gnt = '0;
      endcase
    end
  end

  assign any_gnt   = |gnt;
  assign gnt_owner = gnt[1] ? OWN_M1 : OWN_M0;
  assign sel       = gnt[1] ? m_req[1] : m_req[0];

  // Burst bookkeeping freezes while the controller is not ready.
  always_comb begin
    last_owner_d = last_owner_q;
    burst_cnt_d  = burst_cnt_q;
    if (bus.SRAM_ready) begin
      if (req == '0) begin
        burst_cnt_d = '0;
      end else if (any_gnt) begin
        if (gnt_owner == last_owner_q) begin
          if (burst_cnt_q != BURST_MAX) burst_cnt_d = burst_cnt_q + 4'd1;
        end else begin
          last_owner_d = gnt_owner;
          burst_cnt_d  = 4'd1;
        end
      end
    end
  end

  always_comb begin
    sram_addr_d  = sram_addr_q;
    sram_wdata_d = sram_wdata_q;
    sram_we_n_d  = 1'b1;
    if (any_gnt) begin
      sram_addr_d  = sel.addr;
      sram_wdata_d = sel.wdata;
      sram_we_n_d  = sel.we_n;
    end
  end

  // Tag pipeline shifts every cycle, ready or not, so in-flight reads always drain.
  always_comb begin
    tag_d[0].vld   = any_gnt & sel.we_n;
    tag_d[0].owner = gnt_owner;
    for (int i = 1; i < READ_LATENCY; i++) tag_d[i] = tag_q[i-1];
  end

  for (genvar m = 0; m < NUM_M; m++) begin : g_rv
    assign rv_d[m] = tag_q[READ_LATENCY-1].vld &&
                     (logic'(tag_q[READ_LATENCY-1].owner) == 1'(m));
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      last_owner_q <= OWN_M0;
      burst_cnt_q  <= '0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
      sram_we_n_q  <= 1'b1;
      tag_q        <= '0;
      rv_q         <= '0;
    end else begin
      last_owner_q <= last_owner_d;
      burst_cnt_q  <= burst_cnt_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
      sram_we_n_q  <= sram_we_n_d;
      tag_q        <= tag_d;
      rv_q         <= rv_d;
    end
  end

  assign bus.M0_grant        = gnt[0];
  assign bus.M1_grant        = gnt[1];
  assign bus.M0_read_data    = bus.SRAM_read_data;
  assign bus.M1_read_data    = bus.SRAM_read_data;
  assign bus.M0_read_valid   = rv_q[0];
  assign bus.M1_read_valid   = rv_q[1];
  assign bus.SRAM_address    = sram_addr_q;
  assign bus.SRAM_write_data = sram_wdata_q;
  assign bus.SRAM_we_n       = sram_we_n_q;

  a_rv_onehot:  assert property (@(posedge Clock) disable iff (!Resetn) !(rv_q[0] && rv_q[1]));
  a_gnt_onehot: assert property (@(posedge Clock) disable iff (!Resetn) !(gnt[0] && gnt[1]));
endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: arbitration table, directed multi-cycle sequences,
// and a randomized run against a grant-order memory model.
module tb_sram_arbiter;
  localparam int RL = 3;
  localparam int MB = 4;

  logic Clock = 1'b0;
  logic Resetn;
  int   n_chk  = 0;
  int   n_pass = 0;

  sram_arbiter_if bus ();
  sram_arbiter_if bus1 ();

  sram_arbiter #(.READ_LATENCY(RL), .MAX_BURST(MB)) dut (
    .Clock(Clock), .Resetn(Resetn), .bus(bus.slave));
  sram_arbiter #(.READ_LATENCY(RL), .MAX_BURST(1)) dut_alt (
    .Clock(Clock), .Resetn(Resetn), .bus(bus1.slave));

  always #10 Clock = ~Clock;

  // SRAM_Controller model: address sampled at the edge ending its presentation cycle,
  // read word appears RL cycles after the address was first presented.
  logic [15:0] mem [256];
  logic [15:0] rd_pipe [RL];
  assign bus.SRAM_read_data  = rd_pipe[RL-1];
  assign bus1.SRAM_read_data = 16'h0;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h5000 + 16'(i);
    for (int i = 0; i < RL; i++) rd_pipe[i] = 16'hDEAD;
    forever begin
      @(posedge Clock);
      for (int i = RL - 1; i > 0; i--) rd_pipe[i] = rd_pipe[i-1];
      if (bus.SRAM_we_n === 1'b0) begin
        mem[bus.SRAM_address[7:0]] = bus.SRAM_write_data;
        rd_pipe[0] = 16'hDEAD;
      end else begin
        rd_pipe[0] = mem[bus.SRAM_address[7:0]];
      end
    end
  end

  typedef struct packed {
    logic       rdy;
    logic       r0;
    logic       r1;
    logic [1:0] g;   // {M1_grant, M0_grant}
  } vec_t;
  vec_t tbl [15];

  logic [15:0] shadow [16];
  logic        ev_v [16];
  int          ev_o [16];
  logic [15:0] ev_d [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic next_cycle();
    @(posedge Clock);
    #1;
  endtask

  task automatic mid();
    @(negedge Clock);
  endtask

  task automatic set_m0(input logic r, input logic we, input logic [17:0] a, input logic [15:0] d);
    bus.M0_req = r; bus.M0_we_n = we; bus.M0_address = a; bus.M0_write_data = d;
  endtask

  task automatic set_m1(input logic r, input logic we, input logic [17:0] a, input logic [15:0] d);
    bus.M1_req = r; bus.M1_we_n = we; bus.M1_address = a; bus.M1_write_data = d;
  endtask

  task automatic idle();
    set_m0(1'b0, 1'b1, 18'd0, 16'd0);
    set_m1(1'b0, 1'b1, 18'd0, 16'd0);
    bus.SRAM_ready = 1'b1;
  endtask

  task automatic do_reset();
    idle();
    Resetn = 1'b0;
    repeat (2) next_cycle();
    Resetn = 1'b1;
  endtask

  initial begin
    int owner, cnt, g, s, t;
    int a0, a1, ga;
    logic r0, r1, w0, w1, rdy, gw;
    logic [15:0] d0, d1, gd;
    logic [17:0] exp_addr;
    logic [15:0] exp_wd;
    logic        exp_we;
    logic [1:0]  exp_g;

    tbl = '{
      '{1'b1, 1'b1, 1'b1, 2'b01}, '{1'b1, 1'b1, 1'b1, 2'b01}, '{1'b1, 1'b1, 1'b1, 2'b01},
      '{1'b1, 1'b1, 1'b1, 2'b01}, '{1'b1, 1'b1, 1'b1, 2'b10}, '{1'b1, 1'b1, 1'b1, 2'b10},
      '{1'b0, 1'b1, 1'b1, 2'b00}, '{1'b1, 1'b1, 1'b1, 2'b10}, '{1'b1, 1'b1, 1'b1, 2'b10},
      '{1'b1, 1'b1, 1'b1, 2'b01}, '{1'b1, 1'b0, 1'b1, 2'b10}, '{1'b1, 1'b0, 1'b0, 2'b00},
      '{1'b1, 1'b1, 1'b1, 2'b10}, '{1'b1, 1'b1, 1'b0, 2'b01}, '{1'b1, 1'b1, 1'b1, 2'b01}
    };

    Resetn = 1'b0;
    idle();
    bus1.M0_req = 1'b0; bus1.M0_we_n = 1'b1; bus1.M0_address = '0; bus1.M0_write_data = '0;
    bus1.M1_req = 1'b0; bus1.M1_we_n = 1'b1; bus1.M1_address = '0; bus1.M1_write_data = '0;
    bus1.SRAM_ready = 1'b1;
    repeat (2) next_cycle();
    mid();
    chk("rst_we_n", 32'(bus.SRAM_we_n), 32'd1);
    chk("rst_addr", 32'(bus.SRAM_address), 32'd0);
    chk("rst_wdata", 32'(bus.SRAM_write_data), 32'd0);
    chk("rst_rv", 32'({bus.M1_read_valid, bus.M0_read_valid}), 32'd0);
    next_cycle();
    Resetn = 1'b1;

    // Arbitration table: MAX_BURST=4 contention, ready gap, single requesters, idle.
    for (int i = 0; i < 15; i++) begin
      bus.SRAM_ready = tbl[i].rdy;
      set_m0(tbl[i].r0, 1'b0, 18'd32, 16'(i));
      set_m1(tbl[i].r1, 1'b0, 18'd33, 16'(i));
      mid();
      chk($sformatf("arb_tbl[%0d]", i), 32'({bus.M1_grant, bus.M0_grant}), 32'(tbl[i].g));
      next_cycle();
    end
    idle();
    next_cycle();

    // M0 alone writes four consecutive words.
    for (int k = 0; k < 6; k++) begin
      if (k < 4) set_m0(1'b1, 1'b0, 18'(k), 16'hA000 + 16'(k));
      else idle();
      mid();
      if (k < 4) chk("wr_grant", 32'(bus.M0_grant), 32'd1);
      if (k >= 1 && k <= 4) begin
        chk("wr_we_n", 32'(bus.SRAM_we_n), 32'd0);
        chk("wr_addr", 32'(bus.SRAM_address), 32'(k - 1));
        chk("wr_data", 32'(bus.SRAM_write_data), 32'hA000 + 32'(k - 1));
      end
      if (k == 5) chk("wr_idle_we_n", 32'(bus.SRAM_we_n), 32'd1);
      next_cycle();
    end

    // Asynchronous reset in the middle of a cycle with a request pending.
    set_m0(1'b1, 1'b0, 18'd5, 16'h1111);
    repeat (2) next_cycle();
    mid();
    chk("pre_rst_addr", 32'(bus.SRAM_address), 32'd5);
    Resetn = 1'b0;
    #1;
    chk("async_rst_we_n", 32'(bus.SRAM_we_n), 32'd1);
    chk("async_rst_addr", 32'(bus.SRAM_address), 32'd0);
    chk("async_rst_grant", 32'({bus.M1_grant, bus.M0_grant}), 32'd0);
    chk("async_rst_rv", 32'({bus.M1_read_valid, bus.M0_read_valid}), 32'd0);
    next_cycle();
    Resetn = 1'b1;
    idle();
    next_cycle();

    // Preload addresses 10 and 11 through the arbiter.
    set_m0(1'b1, 1'b0, 18'd10, 16'h1234);
    next_cycle();
    set_m0(1'b0, 1'b1, 18'd0, 16'd0);
    set_m1(1'b1, 1'b0, 18'd11, 16'h5678);
    next_cycle();
    idle();
    repeat (2) next_cycle();

    // M0 reads 10 at t, M1 reads 11 at t+1.
    for (int k = 0; k < 8; k++) begin
      idle();
      if (k == 0) set_m0(1'b1, 1'b1, 18'd10, 16'd0);
      if (k == 1) set_m1(1'b1, 1'b1, 18'd11, 16'd0);
      mid();
      if (k == 0) chk("rd_m0_grant", 32'(bus.M0_grant), 32'd1);
      if (k == 1) chk("rd_m1_grant", 32'(bus.M1_grant), 32'd1);
      chk($sformatf("rd_m0_valid@%0d", k), 32'(bus.M0_read_valid), 32'(k == 4));
      chk($sformatf("rd_m1_valid@%0d", k), 32'(bus.M1_read_valid), 32'(k == 5));
      if (k == 4) chk("rd_m0_data", 32'(bus.M0_read_data), 32'h1234);
      if (k == 5) chk("rd_m1_data", 32'(bus.M1_read_data), 32'h5678);
      next_cycle();
    end

    // Two-master read stream with a three-cycle ready gap.
    do_reset();
    for (int k = 0; k < 13; k++) begin
      idle();
      bus.SRAM_ready = !(k >= 2 && k <= 4);
      if (k <= 7) begin
        set_m0(1'b1, 1'b1, 18'd10, 16'd0);
        set_m1(1'b1, 1'b1, 18'd11, 16'd0);
      end
      mid();
      exp_g = (k == 0 || k == 1 || k == 5 || k == 6) ? 2'b01 : (k == 7) ? 2'b10 : 2'b00;
      chk($sformatf("gap_grant@%0d", k), 32'({bus.M1_grant, bus.M0_grant}), 32'(exp_g));
      if (k >= 3 && k <= 5) chk("gap_we_n", 32'(bus.SRAM_we_n), 32'd1);
      chk($sformatf("gap_m0_valid@%0d", k), 32'(bus.M0_read_valid),
          32'(k == 4 || k == 5 || k == 9 || k == 10));
      chk($sformatf("gap_m1_valid@%0d", k), 32'(bus.M1_read_valid), 32'(k == 11));
      if (k == 5) chk("gap_m0_data", 32'(bus.M0_read_data), 32'h1234);
      if (k == 11) chk("gap_m1_data", 32'(bus.M1_read_data), 32'h5678);
      next_cycle();
    end

    // Reset one cycle after an M1 read grant drops the read and restores M0 priority.
    do_reset();
    set_m1(1'b1, 1'b1, 18'd11, 16'd0);
    mid();
    chk("rstrd_m1_grant", 32'(bus.M1_grant), 32'd1);
    next_cycle();
    idle();
    Resetn = 1'b0;
    next_cycle();
    Resetn = 1'b1;
    for (int j = 0; j < 8; j++) begin
      mid();
      chk($sformatf("rstrd_no_valid@%0d", j), 32'({bus.M1_read_valid, bus.M0_read_valid}), 32'd0);
      next_cycle();
    end
    set_m0(1'b1, 1'b1, 18'd10, 16'd0);
    set_m1(1'b1, 1'b1, 18'd11, 16'd0);
    mid();
    chk("rstrd_m0_first", 32'({bus.M1_grant, bus.M0_grant}), 32'b01);
    next_cycle();
    idle();

    // MAX_BURST=1 instance alternates strictly.
    do_reset();
    bus1.M0_req = 1'b1;
    bus1.M1_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      mid();
      chk($sformatf("alt_grant@%0d", k), 32'({bus1.M1_grant, bus1.M0_grant}),
          (k % 2 == 1) ? 32'b10 : 32'b01);
      next_cycle();
    end
    bus1.M0_req = 1'b0;
    bus1.M1_req = 1'b0;

    // Randomized traffic against a grant-order memory model.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      shadow[i] = mem[i];
      ev_v[i] = 1'b0;
      ev_o[i] = 0;
      ev_d[i] = 16'd0;
    end
    owner = 0; cnt = 0;
    exp_addr = '0; exp_wd = '0; exp_we = 1'b1;
    for (int c = 0; c < 400; c++) begin
      rdy = ($urandom_range(0, 7) != 0);
      r0  = ($urandom_range(0, 3) != 0);
      r1  = ($urandom_range(0, 3) != 0);
      w0  = 1'($urandom_range(0, 1));
      w1  = 1'($urandom_range(0, 1));
      a0  = int'($urandom_range(0, 15));
      a1  = int'($urandom_range(0, 15));
      d0  = 16'($urandom);
      d1  = 16'($urandom);
      bus.SRAM_ready = rdy;
      set_m0(r0, w0, 18'(a0), d0);
      set_m1(r1, w1, 18'(a1), d1);
      mid();
      g = -1;
      if (rdy) begin
        if (r0 && r1) g = (cnt < MB) ? owner : 1 - owner;
        else if (r0) g = 0;
        else if (r1) g = 1;
      end
      exp_g = (g == 1) ? 2'b10 : (g == 0) ? 2'b01 : 2'b00;
      chk("rnd_grant", 32'({bus.M1_grant, bus.M0_grant}), 32'(exp_g));
      chk("rnd_we_n", 32'(bus.SRAM_we_n), 32'(exp_we));
      chk("rnd_addr", 32'(bus.SRAM_address), 32'(exp_addr));
      chk("rnd_wdata", 32'(bus.SRAM_write_data), 32'(exp_wd));
      s = c % 16;
      exp_g = !ev_v[s] ? 2'b00 : (ev_o[s] == 1) ? 2'b10 : 2'b01;
      chk("rnd_rvalid", 32'({bus.M1_read_valid, bus.M0_read_valid}), 32'(exp_g));
      if (ev_v[s])
        chk("rnd_rdata", 32'((ev_o[s] == 1) ? bus.M1_read_data : bus.M0_read_data), 32'(ev_d[s]));
      ev_v[s] = 1'b0;
      if (g >= 0) begin
        ga = (g == 1) ? a1 : a0;
        gw = (g == 1) ? w1 : w0;
        gd = (g == 1) ? d1 : d0;
        if (!gw) begin
          shadow[ga] = gd;
        end else begin
          t = (c + 1 + RL) % 16;
          ev_v[t] = 1'b1;
          ev_o[t] = g;
          ev_d[t] = shadow[ga];
        end
        exp_addr = 18'(ga);
        exp_wd   = gd;
        exp_we   = gw;
      end else begin
        exp_we = 1'b1;
      end
      if (rdy) begin
        if (!r0 && !r1) cnt = 0;
        else if (g == owner) cnt = (cnt < MB) ? cnt + 1 : MB;
        else begin
          owner = g;
          cnt = 1;
        end
      end
      next_cycle();
    end
    idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
